// File: rtl/rib_dma_pkg.sv
// rib_dma_pkg: shared definitions for the RIB word-copy DMA engine.
// Holds the register index map, the CTRL/STATUS bit positions, the FSM
// state encoding, the common bus constants and an address-alignment helper.
package rib_dma_pkg;

    // Common bus constants shared with the rest of the RIB codebase.
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;

    // Register indices as decoded from s_addr_i[4:2] (byte offset = index * 4).
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_SRC    = 3'd2;
    localparam logic [2:0] REG_DST    = 3'd3;
    localparam logic [2:0] REG_LEN    = 3'd4;

    // CTRL bit positions.
    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;

    // STATUS bit positions.
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    // Copy engine states: idle, read beat pending, write beat pending.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } dma_state_e;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rib_dma_regs.sv
// rib_dma_regs: configuration register file and slave read mux of rib_dma.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   s_addr_i/s_data_i   slave address (index in [4:2]) and write data
//   s_we_i              slave write enable
//   s_data_o            slave read data, combinational from s_addr_i
//   busy_s              engine is not idle (blocks SRC/DST/LEN/START writes)
//   set_done_s          engine finished a transfer (or LEN=0 start)
//   set_aborted_s       engine stopped because of an abort
//   clr_status_s        engine launched a transfer; clears DONE and ABORTED
//   start_s, abort_s    qualified one-cycle command pulses to the engine
//   src_r, dst_r, len_r programmed transfer parameters
//   irq_r               registered level interrupt
module rib_dma_regs
    import rib_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      s_addr_i,
    input  logic [31:0]      s_data_i,
    input  logic             s_we_i,
    output logic [31:0]      s_data_o,
    input  logic             busy_s,
    input  logic             set_done_s,
    input  logic             set_aborted_s,
    input  logic             clr_status_s,
    output logic             start_s,
    output logic             abort_s,
    output logic [31:0]      src_r,
    output logic [31:0]      dst_r,
    output logic [LEN_W-1:0] len_r,
    output logic             irq_r
);

    logic [2:0] sel_s;
    logic       wr_ctrl_s;
    logic       wr_status_s;
    logic       wr_src_s;
    logic       wr_dst_s;
    logic       wr_len_s;
    logic       irq_en_r;
    logic       done_r;
    logic       aborted_r;
    logic       unused_s;

    assign sel_s    = s_addr_i[4:2];
    assign unused_s = ^{s_addr_i[31:5], s_addr_i[1:0]};

    // START only launches from idle; ABORT only matters while busy, so a
    // combined START|ABORT write in idle behaves as a plain START.
    assign start_s = wr_ctrl_s & s_data_i[CTRL_START] & ~busy_s;
    assign abort_s = wr_ctrl_s & s_data_i[CTRL_ABORT] & busy_s;

    // Decode which register a config write targets this cycle.
    always_comb begin
        wr_ctrl_s   = WriteDisable;
        wr_status_s = WriteDisable;
        wr_src_s    = WriteDisable;
        wr_dst_s    = WriteDisable;
        wr_len_s    = WriteDisable;
        if (s_we_i == WriteEnable) begin
            case (sel_s)
                REG_CTRL:   wr_ctrl_s   = WriteEnable;
                REG_STATUS: wr_status_s = WriteEnable;
                REG_SRC:    wr_src_s    = WriteEnable;
                REG_DST:    wr_dst_s    = WriteEnable;
                REG_LEN:    wr_len_s    = WriteEnable;
                default:    wr_ctrl_s   = WriteDisable;
            endcase
        end else begin
            wr_ctrl_s = WriteDisable;
        end
    end

    // Register file state, status flags and the registered interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_r  <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            src_r     <= ZeroWord;
            dst_r     <= ZeroWord;
            len_r     <= {LEN_W{1'b0}};
            irq_r     <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                irq_en_r <= s_data_i[CTRL_IRQ_EN];
            end
            // Hardware set outranks a same-cycle write-1-to-clear.
            if (set_done_s) begin
                done_r <= 1'b1;
            end else if (clr_status_s) begin
                done_r <= 1'b0;
            end else if (wr_status_s && s_data_i[STAT_DONE]) begin
                done_r <= 1'b0;
            end
            if (set_aborted_s) begin
                aborted_r <= 1'b1;
            end else if (clr_status_s) begin
                aborted_r <= 1'b0;
            end else if (wr_status_s && s_data_i[STAT_ABORTED]) begin
                aborted_r <= 1'b0;
            end
            if (wr_src_s && !busy_s) begin
                src_r <= word_align(s_data_i);
            end
            if (wr_dst_s && !busy_s) begin
                dst_r <= word_align(s_data_i);
            end
            if (wr_len_s && !busy_s) begin
                len_r <= s_data_i[LEN_W-1:0];
            end
            irq_r <= irq_en_r & (done_r | aborted_r);
        end
    end

    // Slave read mux; unmapped offsets read as zero.
    always_comb begin
        s_data_o = ZeroWord;
        case (sel_s)
            REG_CTRL:   s_data_o[CTRL_IRQ_EN] = irq_en_r;
            REG_STATUS: begin
                s_data_o[STAT_BUSY]    = busy_s;
                s_data_o[STAT_DONE]    = done_r;
                s_data_o[STAT_ABORTED] = aborted_r;
            end
            REG_SRC:    s_data_o = src_r;
            REG_DST:    s_data_o = dst_r;
            REG_LEN:    s_data_o[LEN_W-1:0] = len_r;
            default:    s_data_o = ZeroWord;
        endcase
    end

endmodule

// File: rtl/rib_dma.sv
// rib_dma: word-copy DMA engine, RIB master for the data path and RIB slave
// for its configuration registers. Each word is moved as one read beat
// followed by one write beat; done/aborted raise an optional interrupt.
// Ports:
//   clk, rst                     system clock, synchronous active-high reset
//   s_addr_i/s_data_i/s_we_i     config slave write/address inputs
//   s_data_o                     config read data (combinational)
//   m_addr_o/m_data_o/m_we_o     master address, write data, write flag
//   m_req_o/m_gnt_i              master request and grant
//   m_data_i                     master read data (valid on req & gnt)
//   irq_o                        level interrupt
module rib_dma
    import rib_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_addr_i,
    input  logic [31:0] s_data_i,
    output logic [31:0] s_data_o,
    input  logic        s_we_i,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    input  logic [31:0] m_data_i,
    output logic        m_req_o,
    output logic        m_we_o,
    input  logic        m_gnt_i,
    output logic        irq_o
);

    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};

    dma_state_e       state_r;
    dma_state_e       state_next_s;
    logic [31:0]      cur_src_r;
    logic [31:0]      cur_dst_r;
    logic [LEN_W-1:0] cnt_r;
    logic [31:0]      buf_r;
    logic             abort_pending_r;

    logic             busy_s;
    logic             start_s;
    logic             abort_s;
    logic             set_done_s;
    logic             set_aborted_s;
    logic             load_s;
    logic             rd_beat_s;
    logic             wr_beat_s;
    logic [31:0]      src_r;
    logic [31:0]      dst_r;
    logic [LEN_W-1:0] len_r;
    logic             irq_r;

    assign busy_s = (state_r != ST_IDLE);
    assign irq_o  = irq_r;

    rib_dma_regs #(.LEN_W(LEN_W)) u_regs (
        .clk           (clk),
        .rst           (rst),
        .s_addr_i      (s_addr_i),
        .s_data_i      (s_data_i),
        .s_we_i        (s_we_i),
        .s_data_o      (s_data_o),
        .busy_s        (busy_s),
        .set_done_s    (set_done_s),
        .set_aborted_s (set_aborted_s),
        .clr_status_s  (load_s),
        .start_s       (start_s),
        .abort_s       (abort_s),
        .src_r         (src_r),
        .dst_r         (dst_r),
        .len_r         (len_r),
        .irq_r         (irq_r)
    );

    // Next-state logic and beat/status event strobes.
    always_comb begin
        state_next_s  = state_r;
        set_done_s    = 1'b0;
        set_aborted_s = 1'b0;
        load_s        = 1'b0;
        rd_beat_s     = 1'b0;
        wr_beat_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (len_r == CNT_ZERO) begin
                        set_done_s = 1'b1;
                    end else begin
                        load_s       = 1'b1;
                        state_next_s = ST_RD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD: begin
                // An abort while reading drops the read even if granted.
                if (abort_s) begin
                    set_aborted_s = 1'b1;
                    state_next_s  = ST_IDLE;
                end else if (m_gnt_i) begin
                    rd_beat_s    = 1'b1;
                    state_next_s = ST_WR;
                end else begin
                    state_next_s = ST_RD;
                end
            end
            ST_WR: begin
                if (m_gnt_i) begin
                    wr_beat_s = 1'b1;
                    if (cnt_r == CNT_ONE) begin
                        set_done_s   = 1'b1;
                        state_next_s = ST_IDLE;
                    end else if (abort_pending_r || abort_s) begin
                        set_aborted_s = 1'b1;
                        state_next_s  = ST_IDLE;
                    end else begin
                        state_next_s = ST_RD;
                    end
                end else begin
                    state_next_s = ST_WR;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Master port decode; held constant while a beat waits for grant.
    always_comb begin
        m_req_o  = 1'b0;
        m_we_o   = WriteDisable;
        m_addr_o = ZeroWord;
        m_data_o = ZeroWord;
        case (state_r)
            ST_RD: begin
                m_req_o  = 1'b1;
                m_addr_o = cur_src_r;
            end
            ST_WR: begin
                m_req_o  = 1'b1;
                m_we_o   = WriteEnable;
                m_addr_o = cur_dst_r;
                m_data_o = buf_r;
            end
            default: m_req_o = 1'b0;
        endcase
    end

    // State register, working copies, read buffer and abort latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            cur_src_r       <= ZeroWord;
            cur_dst_r       <= ZeroWord;
            cnt_r           <= CNT_ZERO;
            buf_r           <= ZeroWord;
            abort_pending_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (load_s) begin
                cur_src_r <= src_r;
                cur_dst_r <= dst_r;
                cnt_r     <= len_r;
            end else if (wr_beat_s) begin
                // Plain 32-bit adds wrap past 0xFFFF_FFFC naturally.
                cur_src_r <= cur_src_r + 32'd4;
                cur_dst_r <= cur_dst_r + 32'd4;
                cnt_r     <= cnt_r - CNT_ONE;
            end
            if (rd_beat_s) begin
                buf_r <= m_data_i;
            end
            if (state_next_s == ST_IDLE) begin
                abort_pending_r <= 1'b0;
            end else if (state_r == ST_WR && abort_s) begin
                abort_pending_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rib_dma.sv
// tb_rib_dma: scoreboard bench for rib_dma. Directed stimulus pushes the
// expected master beats into a queue; a negedge monitor pops and compares
// every granted beat. Register/status checks are made inline.
module tb_rib_dma;
    import rib_dma_pkg::*;

    localparam int LEN_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_addr_i;
    logic [31:0] s_data_i;
    logic [31:0] s_data_o;
    logic        s_we_i;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic [31:0] m_data_i;
    logic        m_req_o;
    logic        m_we_o;
    logic        m_gnt_i;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];

    rib_dma #(.LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_addr_i (s_addr_i),
        .s_data_i (s_data_i),
        .s_data_o (s_data_o),
        .s_we_i   (s_we_i),
        .m_addr_o (m_addr_o),
        .m_data_o (m_data_o),
        .m_data_i (m_data_i),
        .m_req_o  (m_req_o),
        .m_we_o   (m_we_o),
        .m_gnt_i  (m_gnt_i),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    // Memory model: read data is a fixed scramble of the address.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    always_comb m_data_i = mem_rd(m_addr_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every granted beat must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (!rst && m_req_o && m_gnt_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: addr 0x%08h we %0b, expected no beat", m_addr_o, m_we_o);
            end else begin
                e = exp_q.pop_front();
                check("beat_we", {31'd0, m_we_o}, {31'd0, e.we});
                check("beat_addr", m_addr_o, e.addr);
                if (e.we) check("beat_wdata", m_data_o, e.data);
            end
        end
    end

    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst);
        exp_q.push_back({1'b0, src, 32'd0});
        exp_q.push_back({1'b1, dst, mem_rd(src)});
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [31:0] d);
        @(posedge clk); #1;
        s_addr_i = {27'd0, idx, 2'b00};
        s_data_i = d;
        s_we_i   = 1'b1;
        @(posedge clk); #1;
        s_we_i   = 1'b0;
    endtask

    task automatic cfg_read(input logic [2:0] idx, output logic [31:0] d);
        s_addr_i = {27'd0, idx, 2'b00};
        #1;
        d = s_data_o;
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] st;
        int n;
        n = 0;
        cfg_read(REG_STATUS, st);
        while (st[STAT_BUSY] && n < budget) begin
            @(posedge clk); #1;
            cfg_read(REG_STATUS, st);
            n++;
        end
        checks++;
        if (st[STAT_BUSY]) begin
            errors++;
            $display("FAIL wait_idle: BUSY still 1 after %0d cycles, expected 0", budget);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] rd;
        rst = 1'b1; s_addr_i = 32'd0; s_data_i = 32'd0; s_we_i = 1'b0; m_gnt_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        check("rst_req", {31'd0, m_req_o}, 32'd0);
        check("rst_we", {31'd0, m_we_o}, 32'd0);
        check("rst_addr", m_addr_o, 32'd0);
        check("rst_wdata", m_data_o, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        cfg_read(REG_STATUS, rd); check("rst_status", rd, 32'd0);
        cfg_read(REG_SRC, rd);    check("rst_src", rd, 32'd0);

        // 1: three-word copy, grant always high, IRQ enabled.
        cfg_write(REG_SRC, 32'h1000_0000);
        cfg_write(REG_DST, 32'h1000_0100);
        cfg_write(REG_LEN, 32'd3);
        m_gnt_i = 1'b1;
        push_copy(32'h1000_0000, 32'h1000_0100);
        push_copy(32'h1000_0004, 32'h1000_0104);
        push_copy(32'h1000_0008, 32'h1000_0108);
        cfg_write(REG_CTRL, 32'h0000_0003);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        cfg_read(REG_STATUS, rd); check("t1_status_done", rd, 32'h0000_0002);
        check("t1_req_idle", {31'd0, m_req_o}, 32'd0);
        check("t1_irq_not_yet", {31'd0, irq_o}, 32'd0);
        cfg_read(REG_CTRL, rd); check("t1_ctrl_readback", rd, 32'h0000_0002);
        @(posedge clk); #1;
        check("t1_irq_set", {31'd0, irq_o}, 32'd1);
        check("t1_queue_empty", exp_q.size(), 32'd0);
        cfg_write(REG_STATUS, 32'h0000_0002);
        check("t1_irq_lag", {31'd0, irq_o}, 32'd1);
        cfg_read(REG_STATUS, rd); check("t1_status_cleared", rd, 32'd0);
        @(posedge clk); #1;
        check("t1_irq_cleared", {31'd0, irq_o}, 32'd0);

        // 2: LEN=0 start, no traffic, DONE immediately.
        cfg_write(REG_LEN, 32'd0);
        cfg_write(REG_CTRL, 32'h0000_0001);
        cfg_read(REG_STATUS, rd); check("t2_status_done", rd, 32'h0000_0002);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_no_req", {31'd0, m_req_o}, 32'd0);
        end

        // 3: read stalled five cycles without grant.
        m_gnt_i = 1'b0;
        cfg_write(REG_SRC, 32'h2000_0000);
        cfg_write(REG_DST, 32'h3000_0000);
        cfg_write(REG_LEN, 32'd1);
        push_copy(32'h2000_0000, 32'h3000_0000);
        cfg_write(REG_CTRL, 32'h0000_0001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_req", {31'd0, m_req_o}, 32'd1);
            check("t3_hold_we", {31'd0, m_we_o}, 32'd0);
            check("t3_hold_addr", m_addr_o, 32'h2000_0000);
        end
        @(posedge clk); #1 m_gnt_i = 1'b1;
        @(negedge clk);
        check("t3_granted_addr", m_addr_o, 32'h2000_0000);
        check("t3_granted_we", {31'd0, m_we_o}, 32'd0);
        wait_idle(20);
        cfg_read(REG_STATUS, rd); check("t3_status_done", rd, 32'h0000_0002);
        m_gnt_i = 1'b0;

        // 4: abort during a stalled write; the write completes, then stop.
        cfg_write(REG_SRC, 32'h4000_0000);
        cfg_write(REG_DST, 32'h5000_0000);
        cfg_write(REG_LEN, 32'd3);
        push_copy(32'h4000_0000, 32'h5000_0000);
        cfg_write(REG_CTRL, 32'h0000_0001);
        m_gnt_i = 1'b1;
        @(posedge clk); #1 m_gnt_i = 1'b0;
        check("t4_in_write", {31'd0, m_we_o}, 32'd1);
        cfg_write(REG_CTRL, 32'h0000_0004);
        @(posedge clk); #1 m_gnt_i = 1'b1;
        @(posedge clk); #1 m_gnt_i = 1'b0;
        cfg_read(REG_STATUS, rd); check("t4_status_aborted", rd, 32'h0000_0004);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_no_more_req", {31'd0, m_req_o}, 32'd0);
        end
        check("t4_queue_empty", exp_q.size(), 32'd0);

        // 5: source address wraps past the top of memory.
        m_gnt_i = 1'b1;
        cfg_write(REG_SRC, 32'hFFFF_FFFC);
        cfg_write(REG_DST, 32'h6000_0000);
        cfg_write(REG_LEN, 32'd2);
        push_copy(32'hFFFF_FFFC, 32'h6000_0000);
        push_copy(32'h0000_0000, 32'h6000_0004);
        cfg_write(REG_CTRL, 32'h0000_0001);
        wait_idle(30);
        cfg_read(REG_STATUS, rd); check("t5_status_done", rd, 32'h0000_0002);
        check("t5_queue_empty", exp_q.size(), 32'd0);

        // 6: SRC write blocked while busy, aligned when idle; abort in RD.
        m_gnt_i = 1'b0;
        cfg_write(REG_SRC, 32'h7000_0000);
        cfg_write(REG_LEN, 32'd1);
        cfg_write(REG_CTRL, 32'h0000_0001);
        cfg_write(REG_SRC, 32'hDEAD_BEEF);
        cfg_read(REG_SRC, rd);    check("t6_src_locked", rd, 32'h7000_0000);
        cfg_read(REG_STATUS, rd); check("t6_status_busy", rd, 32'h0000_0001);
        cfg_write(REG_CTRL, 32'h0000_0004);
        cfg_read(REG_STATUS, rd); check("t6_status_aborted", rd, 32'h0000_0004);
        check("t6_req_dropped", {31'd0, m_req_o}, 32'd0);
        cfg_write(REG_SRC, 32'h1234_5677);
        cfg_read(REG_SRC, rd); check("t6_src_aligned", rd, 32'h1234_5674);
        cfg_write(REG_DST, 32'h1111_1113);
        cfg_read(REG_DST, rd); check("t6_dst_aligned", rd, 32'h1111_1110);
        check("t6_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rib_dma.md
Name: rib_dma

Overview:
- Word-copy DMA engine that acts as an initiator (master) on the RIB interconnect.
- Also acts as a RIB responder (slave) for its own configuration registers.
- Software programs the source, destination and length registers, then writes start. The engine moves words by alternating read and write transfers on its master port, then raises done and an optional interrupt.
- It occupies one master slot and one slave slot on the RIB.

Parameters:
LEN_W, 16, width of the word-count register; maximum transfer is 2^LEN_W-1 words.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
s_addr_i  in  32  config register address; interconnect has already zeroed [31:28]; decode [4:2]
s_data_i  in  32  config write data
s_data_o  out  32  config read data, combinational from s_addr_i
s_we_i  in  1  config write enable
m_addr_o  out  32  master read/write address
m_data_o  out  32  master write data
m_data_i  in  32  master read data, valid in the cycle m_req_o and m_gnt_i are both 1
m_req_o  out  1  master access request
m_we_o  out  1  master write flag
m_gnt_i  in  1  interconnect has selected this master this cycle
irq_o  out  1  interrupt, level

Behaviour:
- Reset (rst=1 at posedge): all registers go to 0 and the state goes to IDLE. Outputs m_req_o=0, m_we_o=0, m_addr_o=0, m_data_o=0, irq_o=0.
- Register map (offset = s_addr_i[4:2]*4):
  - 0x00 CTRL: bit0 START (write 1, self-clearing, reads 0); bit1 IRQ_EN (read/write); bit2 ABORT (write 1, self-clearing, reads 0).
  - 0x04 STATUS: bit0 BUSY (read-only); bit1 DONE (write 1 to clear); bit2 ABORTED (write 1 to clear).
  - 0x08 SRC, 0x0C DST: bits [1:0] are forced to 0 on write.
  - 0x10 LEN: word count, [LEN_W-1:0].
  - Other offsets read 0; writes to them are ignored.
- Config writes take effect at the next posedge. While BUSY, writes to SRC, DST and LEN are ignored, and START is ignored.
- Beat: one transfer completes in any cycle where m_req_o=1 and m_gnt_i=1. There is no timeout: req is held until granted.
- FSM states: IDLE, RD, WR.
  - IDLE: m_req_o=0. On a START write:
    - LEN=0: set DONE, stay IDLE, no bus traffic.
    - Otherwise: load the working counters cur_src, cur_dst and cnt from SRC, DST and LEN; clear DONE and ABORTED; go to RD.
  - RD: m_req_o=1, m_we_o=0, m_addr_o=cur_src. On grant: capture m_data_i into buf and go to WR.
  - WR: m_req_o=1, m_we_o=1, m_addr_o=cur_dst, m_data_o=buf. On grant: cur_src+=4, cur_dst+=4, cnt-=1.
    - If cnt==1 before the decrement: go to IDLE and set DONE.
    - Else if abort_pending: go to IDLE and set ABORTED.
    - Else: go to RD.
- m_req_o, m_we_o and m_addr_o are decoded from state and are stable for the whole time a beat waits for grant.
- Address increments wrap modulo 2^32, e.g. 0xFFFFFFFC+4 = 0x00000000.
- BUSY = (state != IDLE). SRC, DST and LEN keep their programmed values; the working copies are internal.
- ABORT write:
  - In RD: go to IDLE at the next posedge, set ABORTED, and do not issue the read.
  - In WR: set abort_pending; the current write completes, then the engine stops as described above. abort_pending clears on entry to IDLE.
  - In IDLE: no effect.
- Simultaneous events:
  - A DONE write-1-clear in the same cycle as DONE being set: set wins.
  - START and ABORT in the same write while IDLE: START wins and ABORT is ignored.
- irq_o is registered: irq_o <= IRQ_EN & (DONE | ABORTED). It deasserts one cycle after the status bits are cleared.
- rst during a transfer: immediate return to IDLE, no completing write, and all status is cleared.

Decomposition:
- Shared package / defines: register offsets (CTRL, STATUS, SRC, DST, LEN), CTRL and STATUS bit indices, FSM state encodings. Reuse the existing ZeroWord, WriteEnable and WriteDisable constants.
- One natural sub-module, rib_dma_regs: the config register file and slave read mux.
- The FSM and master port stay in rib_dma.

Test Plan:
1. SRC=0x1000_0000, DST=0x1000_0100, LEN=3, m_gnt_i tied 1, START -> exactly 6 beats with alternating addresses 0x..000/0x..100/0x..004/0x..104/0x..008/0x..108; the write data equals the read data. DONE=1, BUSY=0 on the cycle after the 6th beat; irq_o=1 the following cycle if IRQ_EN=1.
2. LEN=0, START -> no m_req_o ever; DONE=1 one cycle after the write.
3. m_gnt_i held 0 for 5 cycles during RD, then 1 -> m_req_o, m_addr_o and m_we_o hold constant for all 6 cycles; exactly one read is captured.
4. ABORT written while in WR with grant low, then grant 2 cycles later -> the pending write completes, state goes to IDLE, ABORTED=1, DONE=0, and no further RD.
5. SRC=0xFFFF_FFFC, LEN=2 -> the second read address is 0x0000_0000.
6. Write SRC=0xDEAD_BEEF while BUSY -> the SRC readback is unchanged. Write SRC=0x1234_5677 while IDLE -> the SRC readback is 0x1234_5674.
